// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: result select, commit,
// two bypassed combinational read ports and a retired-instruction counter.
module wb_regfile #(
    parameter int AWL = 6,
    parameter int DWL = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RegWriteW,
    input  logic             MemtoRegW,
    input  logic             ValidW,
    input  logic [DWL-1:0]   ALUOutW,
    input  logic [DWL-1:0]   ReadDataW,
    input  logic [AWL-2:0]   WriteRegW,
    input  logic [AWL-2:0]   A1,
    input  logic [AWL-2:0]   A2,
    output logic [DWL-1:0]   RD1,
    output logic [DWL-1:0]   RD2,
    output logic [DWL-1:0]   ResultW,
    output logic [DWL-1:0]   InstRetired
);

    localparam int RW   = AWL - 1;
    localparam int NREG = 2 ** RW;

    logic [DWL-1:0] regs_q [NREG];
    logic [DWL-1:0] regs_d [NREG];
    logic [DWL-1:0] inst_retired_q;
    logic [DWL-1:0] inst_retired_d;
    logic           wr_en;

    always_comb begin
        ResultW = MemtoRegW ? ReadDataW : ALUOutW;
        wr_en   = RegWriteW && ValidW && (WriteRegW != '0);
    end

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[WriteRegW] = ResultW;
        end
        inst_retired_d = ValidW ? inst_retired_q + 1'b1 : inst_retired_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            inst_retired_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            inst_retired_q <= inst_retired_d;
        end
    end

    // Each port bypasses independently; reset masks both ports and the bypass.
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (!RST) begin
            if (A1 != '0) begin
                RD1 = (wr_en && (WriteRegW == A1)) ? ResultW : regs_q[A1];
            end
            if (A2 != '0) begin
                RD2 = (wr_en && (WriteRegW == A2)) ? ResultW : regs_q[A2];
            end
        end
    end

    assign InstRetired = inst_retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; a narrow second instance
// exercises the retire-counter wrap in a practical number of cycles.
module tb_wb_regfile;

    logic        CLK;
    logic        RST;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic        ValidW;
    logic [31:0] ALUOutW;
    logic [31:0] ReadDataW;
    logic [4:0]  WriteRegW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic [31:0] InstRetired;

    logic        rst8;
    logic        valid8;
    logic [7:0]  rd1_8;
    logic [7:0]  rd2_8;
    logic [7:0]  result8;
    logic [7:0]  retired8;

    int n_checks;
    int n_fail;

    wb_regfile #(.AWL(6), .DWL(32)) dut (
        .CLK(CLK), .RST(RST), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ValidW(ValidW), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
        .WriteRegW(WriteRegW), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .ResultW(ResultW), .InstRetired(InstRetired)
    );

    wb_regfile #(.AWL(3), .DWL(8)) dut8 (
        .CLK(CLK), .RST(rst8), .RegWriteW(1'b0), .MemtoRegW(1'b0),
        .ValidW(valid8), .ALUOutW(8'h00), .ReadDataW(8'h00),
        .WriteRegW(2'd0), .A1(2'd0), .A2(2'd0), .RD1(rd1_8), .RD2(rd2_8),
        .ResultW(result8), .InstRetired(retired8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RegWriteW = 1'b0;
        MemtoRegW = 1'b0;
        ValidW    = 1'b0;
        ALUOutW   = '0;
        ReadDataW = '0;
        WriteRegW = '0;
    endtask

    task automatic test_reset();
        idle();
        RST       = 1'b1;
        RegWriteW = 1'b1;
        ValidW    = 1'b1;
        ALUOutW   = 32'h000000AA;
        WriteRegW = 5'd5;
        A1        = 5'd5;
        A2        = 5'd31;
        #2;
        n_checks++;
        if (RD1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bypass_masked RD1 got %h expected %h", RD1, 32'h0);
        end
        n_checks++;
        if (ResultW !== 32'h000000AA) begin
            n_fail++;
            $display("FAIL reset_result_mux ResultW got %h expected %h", ResultW, 32'hAA);
        end
        tick();
        RST = 1'b0;
        idle();
        #2;
        n_checks++;
        if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_read RD1/RD2 got %h/%h expected 0/0", RD1, RD2);
        end
        n_checks++;
        if (InstRetired !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_count InstRetired got %h expected 0", InstRetired);
        end
    endtask

    task automatic test_alu_write();
        RegWriteW = 1'b1;
        ValidW    = 1'b1;
        MemtoRegW = 1'b0;
        ALUOutW   = 32'hDEADBEEF;
        ReadDataW = 32'h0BADF00D;
        WriteRegW = 5'd8;
        tick();
        idle();
        A1 = 5'd8;
        #2;
        n_checks++;
        if (RD1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_write RD1 got %h expected %h", RD1, 32'hDEADBEEF);
        end
        n_checks++;
        if (InstRetired !== 32'd1) begin
            n_fail++;
            $display("FAIL alu_write_count InstRetired got %0d expected 1", InstRetired);
        end
    endtask

    task automatic test_bypass();
        RegWriteW = 1'b1;
        ValidW    = 1'b1;
        MemtoRegW = 1'b1;
        ALUOutW   = 32'hCAFE0000;
        ReadDataW = 32'h12345678;
        WriteRegW = 5'd3;
        A1        = 5'd3;
        A2        = 5'd3;
        #2;
        n_checks++;
        if (ResultW !== 32'h12345678) begin
            n_fail++;
            $display("FAIL load_mux ResultW got %h expected %h", ResultW, 32'h12345678);
        end
        n_checks++;
        if (RD1 !== 32'h12345678 || RD2 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_both RD1/RD2 got %h/%h expected 12345678", RD1, RD2);
        end
        tick();
        idle();
        #2;
        n_checks++;
        if (RD1 !== 32'h12345678 || RD2 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL load_commit RD1/RD2 got %h/%h expected 12345678", RD1, RD2);
        end
        n_checks++;
        if (InstRetired !== 32'd2) begin
            n_fail++;
            $display("FAIL bypass_count InstRetired got %0d expected 2", InstRetired);
        end
    endtask

    task automatic test_reg_zero();
        RegWriteW = 1'b1;
        ValidW    = 1'b1;
        ALUOutW   = 32'hFFFFFFFF;
        WriteRegW = 5'd0;
        A1        = 5'd0;
        A2        = 5'd8;
        #2;
        n_checks++;
        if (RD1 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_no_bypass RD1 got %h expected 0", RD1);
        end
        n_checks++;
        if (RD2 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL zero_other_port RD2 got %h expected %h", RD2, 32'hDEADBEEF);
        end
        tick();
        idle();
        #2;
        n_checks++;
        if (RD1 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_after RD1 got %h expected 0", RD1);
        end
        n_checks++;
        if (InstRetired !== 32'd3) begin
            n_fail++;
            $display("FAIL zero_count InstRetired got %0d expected 3", InstRetired);
        end
    endtask

    task automatic test_bubble();
        RegWriteW = 1'b1;
        ValidW    = 1'b1;
        ALUOutW   = 32'h00000011;
        WriteRegW = 5'd9;
        tick();
        ALUOutW   = 32'h00000099;
        ValidW    = 1'b0;
        A1        = 5'd9;
        #2;
        n_checks++;
        if (RD1 !== 32'h00000011) begin
            n_fail++;
            $display("FAIL bubble_no_bypass RD1 got %h expected %h", RD1, 32'h11);
        end
        tick();
        idle();
        #2;
        n_checks++;
        if (RD1 !== 32'h00000011) begin
            n_fail++;
            $display("FAIL bubble_no_write RD1 got %h expected %h", RD1, 32'h11);
        end
        n_checks++;
        if (InstRetired !== 32'd4) begin
            n_fail++;
            $display("FAIL bubble_count InstRetired got %0d expected 4", InstRetired);
        end
    endtask

    task automatic test_back_to_back();
        RegWriteW = 1'b1;
        ValidW    = 1'b1;
        ALUOutW   = 32'h00000100;
        WriteRegW = 5'd10;
        tick();
        ALUOutW   = 32'h00000200;
        WriteRegW = 5'd11;
        A1        = 5'd10;
        A2        = 5'd11;
        #2;
        n_checks++;
        if (RD1 !== 32'h00000100 || RD2 !== 32'h00000200) begin
            n_fail++;
            $display("FAIL b2b_independent RD1/RD2 got %h/%h expected 100/200", RD1, RD2);
        end
        tick();
        idle();
        #2;
        n_checks++;
        if (RD1 !== 32'h00000100 || RD2 !== 32'h00000200) begin
            n_fail++;
            $display("FAIL b2b_commit RD1/RD2 got %h/%h expected 100/200", RD1, RD2);
        end
        n_checks++;
        if (InstRetired !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_count InstRetired got %0d expected 6", InstRetired);
        end
    endtask

    task automatic test_reset_midprogram();
        RST       = 1'b1;
        RegWriteW = 1'b1;
        ValidW    = 1'b1;
        ALUOutW   = 32'h00000044;
        WriteRegW = 5'd4;
        tick();
        RST = 1'b0;
        idle();
        A1 = 5'd4;
        A2 = 5'd8;
        #2;
        n_checks++;
        if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_regs RD1/RD2 got %h/%h expected 0/0", RD1, RD2);
        end
        n_checks++;
        if (InstRetired !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_count InstRetired got %0d expected 0", InstRetired);
        end
    endtask

    task automatic test_counter_wrap();
        rst8   = 1'b1;
        valid8 = 1'b1;
        tick();
        rst8 = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tick();
        end
        n_checks++;
        if (retired8 !== 8'hFF) begin
            n_fail++;
            $display("FAIL wrap_allones InstRetired8 got %h expected ff", retired8);
        end
        tick();
        valid8 = 1'b0;
        n_checks++;
        if (retired8 !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_zero InstRetired8 got %h expected 00", retired8);
        end
        tick();
        n_checks++;
        if (retired8 !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_hold InstRetired8 got %h expected 00", retired8);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        rst8     = 1'b1;
        valid8   = 1'b0;
        A1       = '0;
        A2       = '0;
        idle();
        tick();
        test_reset();
        test_alu_write();
        test_bypass();
        test_reg_zero();
        test_bubble();
        test_back_to_back();
        test_reset_midprogram();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
